// File: rtl/gray_step_sequencer.sv
// rtl/gray_step_sequencer.sv - command-driven Gray-code counter sequencer
// Accepts {start, dir, len} in IDLE, then steps the count once per unpaused cycle.
module gray_step_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_start_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             step,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_MIN = '0;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_len;
                    // A load only repositions the counter; it is not a step.
                    if (cmd_load) begin
                        bin_d = cmd_start_val;
                    end
                    state_d = (cmd_len != LEN_ZERO) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // Abort outranks both pause and a pending final step.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    bin_d  = dir_q ? (bin_q + 1'b1) : (bin_q - 1'b1);
                    rem_d  = rem_q - 1'b1;
                    step_d = 1'b1;
                    wrap_d = dir_q ? (bin_q == BIN_MAX) : (bin_q == BIN_MIN);
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign bin_out   = bin_q;
    assign gray_out  = bin_q ^ (bin_q >> 1);
    assign step      = step_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// tb/tb_gray_step_sequencer.sv - scoreboard bench for gray_step_sequencer
module tb_gray_step_sequencer;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_dir = 1'b0;
    logic             cmd_load = 1'b0;
    logic [WIDTH-1:0] cmd_start_val = '0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             step;
    logic             wrap;
    logic             busy;
    logic             done;

    gray_step_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_dir(cmd_dir), .cmd_load(cmd_load),
        .cmd_start_val(cmd_start_val),
        .pause(pause), .abort(abort),
        .bin_out(bin_out), .gray_out(gray_out),
        .step(step), .wrap(wrap), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic [WIDTH-1:0] gray;
        logic             wrp;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    int         k_acc = 0;
    int         d_cyc = 0;
    logic [WIDTH-1:0] m_bin = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every step pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (step) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_step", 32'(bin_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("step_bin", 32'(bin_out), 32'(e.bin));
                chk("step_gray", 32'(gray_out), 32'(e.gray));
                chk("step_wrap", 32'(wrap), 32'(e.wrp));
            end
        end else begin
            chk("wrap_without_step", 32'(wrap), 32'd0);
        end
    end

    task automatic send_cmd(input int len, input logic dir, input logic load,
                            input logic [WIDTH-1:0] start, input int n_push);
        exp_t e;
        @(negedge clk);
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_len       = LEN_W'(len);
        cmd_dir       = dir;
        cmd_load      = load;
        cmd_start_val = start;
        if (load) m_bin = start;
        for (int i = 0; i < n_push; i++) begin
            e.wrp = dir ? (m_bin == 4'hF) : (m_bin == 4'h0);
            m_bin = dir ? m_bin + 4'd1 : m_bin - 4'd1;
            e.bin = m_bin;
            e.gray = m_bin ^ (m_bin >> 1);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k_acc = cyc;
    endtask

    task automatic wait_done(input int budget, output int dc);
        bit seen;
        seen = 0;
        dc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                dc = cyc;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        edges(2);
        @(negedge clk);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_gray", 32'(gray_out), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;

        // Full up sweep from 0, 16 steps, wrap on last
        send_cmd(16, 1'b1, 1'b1, 4'd0, 16);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cmd_ready_run", 32'(cmd_ready), 32'd0);
        wait_done(40, d_cyc);
        exp_done++;
        chk("t1_done_latency", 32'(d_cyc - k_acc), 32'd16);
        chk("t1_bin_end", 32'(bin_out), 32'd0);
        chk("t1_cmd_ready_in_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        chk("t1_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Down from 3, 5 steps, wrap 0->15
        send_cmd(5, 1'b0, 1'b1, 4'd3, 5);
        wait_done(20, d_cyc);
        exp_done++;
        chk("t2_done_latency", 32'(d_cyc - k_acc), 32'd5);
        @(negedge clk);
        chk("t2_bin_end", 32'(bin_out), 32'd14);
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Pause for 3 cycles after 2nd step
        send_cmd(4, 1'b1, 1'b1, 4'd5, 4);
        edges(2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) pause = 1'b0;
            @(negedge clk);
            chk("t3_pause_no_step", 32'(step), 32'd0);
            chk("t3_pause_hold", 32'(bin_out), 32'd7);
            chk("t3_pause_busy", 32'(busy), 32'd1);
        end
        wait_done(20, d_cyc);
        exp_done++;
        chk("t3_done_latency", 32'(d_cyc - k_acc), 32'd7);
        chk("t3_bin_end", 32'(bin_out), 32'd9);
        @(negedge clk);
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Abort after 2nd step, then continue without load
        send_cmd(10, 1'b1, 1'b1, 4'd0, 2);
        edges(2);
        abort = 1'b1;
        edges(1);
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_bin", 32'(bin_out), 32'd2);
        chk("t4_abort_ready", 32'(cmd_ready), 32'd1);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_no_done", 32'(done_cnt), 32'(exp_done));
        send_cmd(1, 1'b1, 1'b0, 4'd0, 1);
        wait_done(10, d_cyc);
        exp_done++;
        chk("t4_cont_bin", 32'(bin_out), 32'd3);

        // Pause then abort with pause still high
        send_cmd(10, 1'b1, 1'b1, 4'd0, 2);
        edges(2);
        pause = 1'b1;
        edges(1);
        abort = 1'b1;
        edges(1);
        pause = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_bin", 32'(bin_out), 32'd2);
        chk("t5_abort_ready", 32'(cmd_ready), 32'd1);
        chk("t5_abort_no_done", 32'(done_cnt), 32'(exp_done));
        chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Zero-length command with load
        send_cmd(0, 1'b1, 1'b1, 4'd9, 0);
        @(negedge clk);
        chk("t6_len0_done", 32'(done), 32'd1);
        chk("t6_len0_bin", 32'(bin_out), 32'd9);
        chk("t6_len0_no_step", 32'(step), 32'd0);
        d_cyc = cyc;
        exp_done++;
        chk("t6_done_latency", 32'(d_cyc - k_acc), 32'd0);

        // cmd_valid held through RUN and DONE must not be taken
        send_cmd(3, 1'b1, 1'b0, 4'd0, 3);
        cmd_valid     = 1'b1;
        cmd_len       = 8'd7;
        cmd_load      = 1'b1;
        cmd_start_val = 4'd0;
        wait_done(10, d_cyc);
        exp_done++;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t7_bin_hold", 32'(bin_out), 32'd12);
        chk("t7_idle_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("t7_still_idle", 32'(cmd_ready), 32'd1);
        chk("t7_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Reset mid-run
        send_cmd(10, 1'b1, 1'b1, 4'd0, 2);
        edges(2);
        rst_n = 1'b0;
        edges(1);
        rst_n = 1'b1;
        m_bin = '0;
        @(negedge clk);
        chk("t8_rst_bin", 32'(bin_out), 32'd0);
        chk("t8_rst_gray", 32'(gray_out), 32'd0);
        chk("t8_rst_step", 32'(step), 32'd0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_done", 32'(done), 32'd0);
        chk("t8_rst_ready", 32'(cmd_ready), 32'd1);
        edges(3);
        @(negedge clk);
        chk("t8_no_done", 32'(done_cnt), 32'(exp_done));
        chk("t8_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
